fifo_rr_scheduler: RTL and testbench
====================================

Name: fifo_rr_scheduler

Overview:
Round-robin read scheduler that drains NUM_CH synchronous FIFOs into one shared output stream with valid/ready backpressure. It watches each FIFO's empty flag, drives the per-FIFO read enables, absorbs the FIFOs' one-cycle registered read latency, and tags each word with its source channel. It sits between the per-source FifoSync instances and a single downstream consumer, for example a UART TX or bus master.

Parameters:
- DATA_W, 8, width of each FIFO word.
- NUM_CH, 4, number of FIFOs served (2..16).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).
- MAX_BURST, 4, max consecutive reads granted to one channel before re-arbitration (1..255).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  permits new grants and reads; 0 pauses issuing.
- fifo_is_empty  in  NUM_CH  per-FIFO empty flag; bit i is FIFO i.
- fifo_read_en  out  NUM_CH  per-FIFO read strobe; at most one bit high per cycle.
- fifo_data  in  NUM_CH*DATA_W  packed FIFO outputs; FIFO i occupies bits [i*DATA_W +: DATA_W].
- out_data  out  DATA_W  head word of the output buffer.
- out_ch  out  CH_W  source channel of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- FIFO contract:
  - read_en[i] at cycle T with !is_empty[i] pops FIFO i.
  - The word appears on fifo_data slice i after edge T+1; is_empty[i] reflects the pop from T+1.
  - The scheduler never asserts read_en[i] while fifo_is_empty[i]=1.
- Output buffer: 2-entry FIFO (occ 0..2) plus an inflight flag (1 when a read was issued the previous cycle).
  - At edge T+1 after a read at T, the captured slice and channel are written to the buffer.
  - out_valid = (occ != 0), so first-word latency is read_en at T0 → out_valid in T0+2.
- Space rule: a read may issue in a cycle only if occ + inflight − pop < 2, where pop = out_valid && out_ready. This sustains 1 word/cycle with out_ready=1 and never overflows.
- State machine (state, cur_ch, last_ch, burst_cnt):
  - IDLE: candidate = first channel with !is_empty, searched cyclically from last_ch+1 through last_ch+NUM_CH (mod NUM_CH).
    - If enable, a candidate exists and space is available: assert read_en[candidate] this cycle, cur_ch=last_ch=candidate, burst_cnt=1, go to BURST.
    - Otherwise stay in IDLE.
  - BURST: if enable && !is_empty[cur_ch] && burst_cnt < MAX_BURST && space → read, burst_cnt++.
    - Else, if the stall is only for space, stay in BURST.
    - Otherwise go to IDLE: on empty, burst_cnt==MAX_BURST, or enable=0.
  - The return to IDLE costs one bubble cycle; no read issues in the transition cycle.
- enable=0: no new reads. The inflight word is still captured and the buffer drains normally.
- Simultaneous capture and pop with occ=2 is impossible by the space rule. With occ=1, capture plus pop keeps occ=1.
- Reset values:
  - state=IDLE, last_ch=NUM_CH-1 (first search starts at ch0), burst_cnt=0.
  - occ=0, inflight=0, out_valid=0, fifo_read_en=0, out_data=0, out_ch=0.
- Reset mid-operation: buffered and inflight words are discarded. FIFOs are not reset by this block, so a word popped in the reset cycle is lost.
- read_en is combinational from registered state and current inputs, and is forced to 0 while reset=1.

Test Plan:
1. Reset, then FIFOs all empty with enable=1 for 20 cycles → fifo_read_en=0 and out_valid=0 throughout.
2. Ch2 holds 0xA1,0xA2,0xA3, out_ready=1:
   - fifo_read_en=4'b0100 for exactly 3 consecutive cycles starting T0.
   - out_valid in T0+2..T0+4 with data A1,A2,A3 and out_ch=2.
3. MAX_BURST=4, ch0 holds 6 words, ch1 holds 2 words, out_ready=1 → out_ch sequence 0,0,0,0,1,1,0,0; no words lost or reordered.
4. Ch1 holds 5 words, out_ready=0:
   - exactly 2 reads issue, then out_valid=1 holds first word stable.
   - Release out_ready → all 5 words delivered in order; read_en never asserts while empty.
5. last_ch=3, ch0 and ch3 both nonempty → next grant is ch0 (wrap-around fairness).
6. Reset asserted mid-burst (ch0 inflight, occ=1) → next cycle out_valid=0 and read_en=0. After release, arbitration restarts at ch0 with the remaining FIFO contents.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler: drains NUM_CH synchronous FIFOs into a single
// valid/ready stream and tags each word with its source channel. FIFO reads
// have one cycle of registered latency. A 2-entry skid buffer plus an
// inflight flag absorbs that latency without ever overflowing.
module fifo_rr_scheduler #(
   parameter int DATA_W    = 8,
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 2,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        fifo_is_empty,
   output logic [NUM_CH-1:0]        fifo_read_en,
   input  logic [NUM_CH*DATA_W-1:0] fifo_data,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_valid,
   input  logic                     out_ready
);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   localparam logic [7:0]      MAX_B8   = 8'(MAX_BURST);
   localparam logic [CH_W-1:0] LAST_CH0 = CH_W'(NUM_CH - 1);

   // arbitration state
   state_t            state_q, state_d;
   logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]   last_ch_q, last_ch_d;
   logic [7:0]        burst_cnt_q, burst_cnt_d;

   // output buffer state
   logic [1:0]        occ_q, occ_d;
   logic              inflight_q, inflight_d;
   logic [CH_W-1:0]   infl_ch_q, infl_ch_d;
   logic [DATA_W-1:0] buf_data_q [2];
   logic [DATA_W-1:0] buf_data_d [2];
   logic [CH_W-1:0]   buf_ch_q [2];
   logic [CH_W-1:0]   buf_ch_d [2];

   logic              pop, push, space;
   logic              rd_go;
   logic [CH_W-1:0]   rd_ch;
   logic              cand_vld;
   logic [CH_W-1:0]   cand_ch;
   logic [DATA_W-1:0] cap_data;
   logic [1:0]        wr_pos;

   // (base + k) mod NUM_CH, also correct when NUM_CH is not a power of two
   function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % NUM_CH;
      return CH_W'(s);
   endfunction

   assign pop       = (occ_q != 2'd0) && out_ready;
   assign push      = inflight_q;
   assign out_valid = (occ_q != 2'd0);
   assign out_data  = buf_data_q[0];
   assign out_ch    = buf_ch_q[0];

   // a read is allowed only if the word it produces is guaranteed a buffer slot
   always_comb begin
      space = ({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
   end

   // cyclic search starting just after the last granted channel; walking k
   // downwards lets the nearest nonempty channel win
   always_comb begin
      cand_vld = 1'b0;
      cand_ch  = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         if (!fifo_is_empty[ch_add(last_ch_q, k)]) begin
            cand_vld = 1'b1;
            cand_ch  = ch_add(last_ch_q, k);
         end
      end
   end

   // grant / burst control; the read strobe is combinational, so it is
   // gated off while reset is high to avoid popping words that would be lost
   always_comb begin
      state_d     = state_q;
      cur_ch_d    = cur_ch_q;
      last_ch_d   = last_ch_q;
      burst_cnt_d = burst_cnt_q;
      rd_go       = 1'b0;
      rd_ch       = cur_ch_q;
      case (state_q)
         S_IDLE: begin
            if (enable && cand_vld && space) begin
               rd_go       = 1'b1;
               rd_ch       = cand_ch;
               cur_ch_d    = cand_ch;
               last_ch_d   = cand_ch;
               burst_cnt_d = 8'd1;
               state_d     = S_BURST;
            end
         end
         S_BURST: begin
            if (enable && !fifo_is_empty[cur_ch_q] && (burst_cnt_q < MAX_B8)) begin
               // a stall caused only by lack of space keeps the burst alive
               if (space) begin
                  rd_go       = 1'b1;
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (reset) rd_go = 1'b0;
   end

   // one-hot read strobe
   always_comb begin
      fifo_read_en = rd_go ? (NUM_CH'(1) << rd_ch) : '0;
   end

   // select the slice of the channel whose read was issued last cycle
   always_comb begin
      cap_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (infl_ch_q == CH_W'(i)) cap_data = fifo_data[i*DATA_W +: DATA_W];
      end
   end

   // output buffer: head always in slot 0, pop shifts, capture goes to the
   // first free slot after the pop
   always_comb begin
      buf_data_d = buf_data_q;
      buf_ch_d   = buf_ch_q;
      if (pop) begin
         buf_data_d[0] = buf_data_q[1];
         buf_ch_d[0]   = buf_ch_q[1];
      end
      wr_pos = occ_q - {1'b0, pop};
      if (push) begin
         if (wr_pos == 2'd0) begin
            buf_data_d[0] = cap_data;
            buf_ch_d[0]   = infl_ch_q;
         end else begin
            buf_data_d[1] = cap_data;
            buf_ch_d[1]   = infl_ch_q;
         end
      end
      occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
      inflight_d = rd_go;
      infl_ch_d  = rd_ch;
   end

   // arbitration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_ch_q    <= '0;
         last_ch_q   <= LAST_CH0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cur_ch_q    <= cur_ch_d;
         last_ch_q   <= last_ch_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // buffer registers; reset discards buffered and inflight words
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= '0;
         inflight_q <= 1'b0;
         infl_ch_q  <= '0;
         buf_data_q <= '{default: '0};
         buf_ch_q   <= '{default: '0};
      end else begin
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         infl_ch_q  <= infl_ch_d;
         buf_data_q <= buf_data_d;
         buf_ch_q   <= buf_ch_d;
      end
   end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: behavioural FIFO models feed the DUT, and a
// scoreboard of expected {channel,data} words is checked at each handshake.
module tb_fifo_rr_scheduler;

   localparam int DATA_W = 8;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     enable;
   logic [NUM_CH-1:0]        fe = '1;
   logic [NUM_CH-1:0]        rd_en;
   logic [NUM_CH*DATA_W-1:0] fd = '0;
   logic [DATA_W-1:0]        out_data;
   logic [CH_W-1:0]          out_ch;
   logic                     out_valid;
   logic                     out_ready;

   fifo_rr_scheduler #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .MAX_BURST(4)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_is_empty(fe), .fifo_read_en(rd_en), .fifo_data(fd),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // FIFO models: registered read data, empty flag updated after the edge
   logic [7:0] fq [NUM_CH][$];
   logic       ld_en;
   int         ld_ch;
   logic [7:0] ld_val;
   logic [7:0] pw;
   always @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_en[i] && fq[i].size() != 0) begin
            pw = fq[i].pop_front();
            fd[i*DATA_W +: DATA_W] <= pw;
         end
         if (ld_en && ld_ch == i) fq[i].push_back(ld_val);
         fe[i] <= (fq[i].size() == 0);
      end
   end

   int         n_chk = 0;
   int         n_fail = 0;
   logic [9:0] exp_q [$];
   logic [9:0] e;
   logic [NUM_CH-1:0] s_rd;
   logic       s_vld;
   logic [7:0] s_data;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // one clock: sample/score at negedge, return just after the next posedge
   task automatic tick();
      @(negedge clk);
      s_rd   = rd_en;
      s_vld  = out_valid;
      s_data = out_data;
      chk("rd_on_empty", 32'(rd_en & fe), 0);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("out_extra", 32'(out_valid), 0);
         else begin
            e = exp_q.pop_front();
            chk("out_word", 32'({out_ch, out_data}), 32'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int ch, input int n, input logic [7:0] base, input bit add_exp);
      for (int j = 0; j < n; j++) begin
         ld_en  = 1'b1;
         ld_ch  = ch;
         ld_val = base + 8'(j);
         if (add_exp) exp_q.push_back({2'(ch), base + 8'(j)});
         tick();
      end
      ld_en = 1'b0;
   endtask

   task automatic exp_push(input int ch, input logic [7:0] d);
      exp_q.push_back({2'(ch), d});
   endtask

   task automatic reset_dut();
      enable = 1'b0;
      reset  = 1'b1;
      tick();
      tick();
      chk("rst_vld", 32'(s_vld), 0);
      chk("rst_rd", 32'(s_rd), 0);
      chk("rst_data", 32'(s_data), 0);
      chk("rst_ch", 32'(out_ch), 0);
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_drained"}, 32'(exp_q.size()), 0);
      repeat (4) tick();
   endtask

   int t3_ch [11] = '{0, 0, 0, 0, -1, 1, 1, -1, 0, 0, -1};
   int nrd;

   initial begin
      reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
      ld_en = 1'b0; ld_ch = 0; ld_val = '0;

      // 1: all empty, enabled
      reset_dut();
      enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("t1_rd", 32'(s_rd), 0);
         chk("t1_vld", 32'(s_vld), 0);
      end

      // 2: three words on ch2, latency and strobe timing
      reset_dut();
      load(2, 3, 8'hA1, 1'b1);
      enable = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("t2_rd", 32'(s_rd), (k < 3) ? 32'h4 : 32'h0);
         chk("t2_vld", 32'(s_vld), (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
      end
      drain("t2");

      // 3: burst limit and alternation
      reset_dut();
      load(0, 6, 8'h10, 1'b0);
      load(1, 2, 8'h20, 1'b0);
      for (int j = 0; j < 4; j++) exp_push(0, 8'h10 + 8'(j));
      exp_push(1, 8'h20); exp_push(1, 8'h21);
      exp_push(0, 8'h14); exp_push(0, 8'h15);
      enable = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         chk("t3_rd", 32'(s_rd), (t3_ch[k] < 0) ? 32'h0 : (32'h1 << t3_ch[k]));
      end
      drain("t3");

      // 4: backpressure
      reset_dut();
      load(1, 5, 8'h30, 1'b1);
      out_ready = 1'b0;
      enable = 1'b1;
      nrd = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (s_rd != 0) nrd++;
         if (k >= 2) chk("t4_hold", 32'({s_vld, s_data}), 32'h130);
      end
      chk("t4_nrd", 32'(nrd), 2);
      out_ready = 1'b1;
      drain("t4");

      // 5: wrap-around from last_ch=3
      reset_dut();
      load(3, 1, 8'h53, 1'b0);
      load(0, 1, 8'h50, 1'b0);
      exp_push(0, 8'h50);
      exp_push(3, 8'h53);
      enable = 1'b1;
      tick(); chk("t5_first", 32'(s_rd), 32'h1);
      tick();
      tick(); chk("t5_second", 32'(s_rd), 32'h8);
      drain("t5");

      // 6: reset mid-burst
      reset_dut();
      load(0, 4, 8'h60, 1'b0);
      exp_push(0, 8'h60);
      exp_push(0, 8'h62);
      exp_push(0, 8'h63);
      enable = 1'b1;
      tick(); chk("t6_rd0", 32'(s_rd), 32'h1);
      tick(); chk("t6_rd1", 32'(s_rd), 32'h1);
      reset = 1'b1;
      tick(); chk("t6_rd_rst", 32'(s_rd), 0);
      tick(); chk("t6_vld_rst", 32'(s_vld), 0);
      chk("t6_rd_rst2", 32'(s_rd), 0);
      reset = 1'b0;
      tick(); chk("t6_regrant", 32'(s_rd), 32'h1);
      drain("t6");
      chk("t6_fifo_empty", 32'(fe[0]), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
